// File: rtl/ring_osc_scan_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator scan controller.
package ring_osc_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    GATE   = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam int unsigned DRAIN_CYC   = 3;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/ring_osc_scan_ctrl_edge_counter.sv
// Synchronizes one asynchronous RO output, detects rising edges and counts
// them into a saturating counter with an overflow flag.
module ro_edge_counter
  import ring_osc_scan_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             ro_in,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic                   rise;

  assign rise = sync[SYNC_STAGES-1] & ~s2;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sync  <= '0;
      s2    <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_in};
      s2   <= sync[SYNC_STAGES-1];
      if (cnt_en && rise) begin
        // edges arriving at all-ones are dropped and flagged, never wrapped
        if (count == '1) ovf   <= 1'b1;
        else             count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ring_osc_scan_ctrl.sv
// Time-shares a bank of ring oscillators: enables one at a time, settles,
// counts edges over a gate window and publishes the result via valid/ready.
module ring_osc_scan_ctrl
  import ring_osc_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RO     = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              scan,
  input  logic [SEL_W-1:0]  sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              abort,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEL_W-1:0]  res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf
);

  localparam int unsigned TMR_W = (GATE_W > $clog2(SETTLE_CYC) + 1) ? GATE_W
                                                                    : $clog2(SETTLE_CYC) + 1;

  state_t              state, nxt_state;
  logic [TMR_W-1:0]    tmr, nxt_tmr;
  logic [SEL_W-1:0]    cur, nxt_cur;
  logic [NUM_RO-1:0]   nxt_en;
  logic                scan_q, nxt_scan;
  logic [GATE_W-1:0]   gate_q, nxt_gate;
  logic                load_en;
  logic                clr;
  logic                cnt_en;
  logic                ro_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tmr    <= '0;
      cur    <= '0;
      ro_en  <= '0;
      scan_q <= 1'b0;
      gate_q <= '0;
    end else begin
      state  <= nxt_state;
      tmr    <= nxt_tmr;
      cur    <= nxt_cur;
      ro_en  <= nxt_en;
      scan_q <= nxt_scan;
      gate_q <= nxt_gate;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_tmr   = tmr;
    nxt_cur   = cur;
    nxt_en    = ro_en;
    nxt_scan  = scan_q;
    nxt_gate  = gate_q;
    load_en   = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (start && !abort && (scan || 32'(sel) < NUM_RO)) begin
          nxt_scan  = scan;
          nxt_gate  = gate_cycles;
          nxt_cur   = scan ? '0 : sel;
          load_en   = 1'b1;
          nxt_tmr   = TMR_W'(SETTLE_CYC - 1);
          nxt_state = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          if (gate_q == '0) begin
            nxt_en    = '0;
            nxt_tmr   = TMR_W'(DRAIN_CYC - 1);
            nxt_state = DRAIN;
          end else begin
            nxt_tmr   = TMR_W'(gate_q) - TMR_W'(1);
            nxt_state = GATE;
          end
        end else begin
          nxt_tmr = tmr - TMR_W'(1);
        end
      end
      GATE: begin
        if (tmr == '0) begin
          nxt_en    = '0;
          nxt_tmr   = TMR_W'(DRAIN_CYC - 1);
          nxt_state = DRAIN;
        end else begin
          nxt_tmr = tmr - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (tmr == '0) nxt_state = REPORT;
        else           nxt_tmr   = tmr - TMR_W'(1);
      end
      REPORT: begin
        if (res_ready) begin
          clr = 1'b1;
          if (scan_q && 32'(cur) < NUM_RO - 1) begin
            nxt_cur   = cur + SEL_W'(1);
            load_en   = 1'b1;
            nxt_tmr   = TMR_W'(SETTLE_CYC - 1);
            nxt_state = SETTLE;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (load_en) begin
      for (int unsigned i = 0; i < NUM_RO; i++) nxt_en[i] = (nxt_cur == SEL_W'(i));
    end
    if (abort && state != IDLE) begin
      nxt_state = IDLE;
      nxt_en    = '0;
      nxt_cur   = cur;
    end
  end

  always_comb begin
    ro_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (cur == SEL_W'(i)) ro_sel = ro_out[i];
    end
  end

  // with a zero-length gate the drain must not pick up settle-period edges
  assign cnt_en = (state == GATE) || (state == DRAIN && gate_q != '0);

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .cnt_en(cnt_en),
    .ro_in (ro_sel),
    .count (res_count),
    .ovf   (res_ovf)
  );

  assign busy      = (state != IDLE);
  assign res_valid = (state == REPORT);
  assign res_id    = cur;

endmodule

// File: tb/tb_ring_osc_scan_ctrl.sv
// Directed bench for ring_osc_scan_ctrl with behavioural ring oscillators.
module tb_ring_osc_scan_ctrl;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] gate;
    int          period;
    logic [2:0]  exp_id;
    int          exp_cnt;
    int          tol;
    int          exp_en;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, scan = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [2:0]  sel = '0;
  logic [15:0] gate_cycles = '0;
  logic [3:0]  ro_out, ro_en;
  logic        busy, res_valid, res_ovf;
  logic [2:0]  res_id;
  logic [15:0] res_count;

  logic        start2 = 1'b0;
  logic [3:0]  ro_out2, ro_en2;
  logic        busy2, res_valid2, res_ovf2;
  logic [1:0]  res_id2;
  logic [3:0]  res_count2;
  logic        fro = 1'b0;

  int half_ns [4] = '{20, 20, 20, 20};
  int n_cmp = 0;
  int n_bad = 0;
  logic mh = 1'b0;

  always #5 clk = ~clk;

  ring_osc_scan_ctrl #(
    .NUM_RO(4), .SEL_W(3), .CNT_W(16), .GATE_W(16), .SETTLE_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .scan(scan), .sel(sel),
    .gate_cycles(gate_cycles), .abort(abort), .ro_out(ro_out), .ro_en(ro_en),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_count(res_count), .res_ovf(res_ovf)
  );

  ring_osc_scan_ctrl #(
    .NUM_RO(4), .SEL_W(2), .CNT_W(4), .GATE_W(16), .SETTLE_CYC(16)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .scan(1'b0), .sel(2'd0),
    .gate_cycles(16'd100), .abort(1'b0), .ro_out(ro_out2), .ro_en(ro_en2),
    .busy(busy2), .res_valid(res_valid2), .res_ready(1'b1), .res_id(res_id2),
    .res_count(res_count2), .res_ovf(res_ovf2)
  );

  // each RO toggles every half period while enabled, 3 ns off the clock grid
  for (genvar g = 0; g < 4; g++) begin : g_ro
    logic r = 1'b0;
    assign ro_out[g] = r;
    always begin
      if (ro_en[g]) begin
        #3;
        while (ro_en[g]) begin
          #(half_ns[g]);
          if (ro_en[g]) r = ~r;
        end
      end else begin
        @(posedge ro_en[g]);
      end
    end
  end

  initial begin
    #3;
    forever #20 fro = ~fro;
  end
  assign ro_out2 = {4{fro}};

  always @(negedge clk) if (!$onehot0(ro_en)) mh = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic start_op(input logic sc, input logic [2:0] s, input logic [15:0] g);
    @(posedge clk); #1;
    start = 1'b1; scan = sc; sel = s; gate_cycles = g;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
    end
    chk({nm, "_timeout"}, ok, 1);
  endtask

  task automatic run_single(input vec_t v, input string nm);
    logic [3:0] oh;
    int en_cnt = 0;
    bit ok = 0;
    oh = 4'b0001 << v.sel;
    half_ns[v.sel] = v.period / 2;
    start_op(1'b0, v.sel, v.gate);
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
      else if (ro_en == oh) en_cnt++;
    end
    chk({nm, "_timeout"}, ok, 1);
    chk({nm, "_en_cycles"}, en_cnt, v.exp_en);
    chk({nm, "_id"}, res_id, v.exp_id);
    chk_rng({nm, "_count"}, res_count, v.exp_cnt - v.tol, v.exp_cnt + v.tol);
    chk({nm, "_ovf"}, res_ovf, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    vec_t vt [5];
    logic [2:0]  id0;
    logic [15:0] c0;
    bit stable, seen, ok;
    int exp_scan [4] = '{50, 33, 25, 20};

    vt[0] = '{3'd2, 16'd100, 40, 3'd2, 25, 1, 116};
    vt[1] = '{3'd0, 16'd100, 100, 3'd0, 10, 1, 116};
    vt[2] = '{3'd1, 16'd120, 60, 3'd1, 20, 1, 136};
    vt[3] = '{3'd3, 16'd0, 40, 3'd3, 0, 0, 16};
    vt[4] = '{3'd3, 16'd50, 40, 3'd3, 12, 1, 66};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_count", res_count, 0);
    chk("rst_ovf", res_ovf, 0);

    for (int i = 0; i < 5; i++) run_single(vt[i], $sformatf("single%0d", i));

    // scan with continuous accept
    half_ns = '{20, 30, 40, 50};
    start_op(1'b1, 3'd0, 16'd200);
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("scan%0d", k), 3000);
      chk($sformatf("scan%0d_id", k), res_id, k);
      chk_rng($sformatf("scan%0d_count", k), res_count, exp_scan[k] - 1, exp_scan[k] + 1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("scan_done_busy", busy, 0);

    // backpressure then abort mid-GATE on RO1
    half_ns = '{20, 20, 20, 20};
    res_ready = 1'b0;
    start_op(1'b1, 3'd0, 16'd20);
    wait_valid("bp", 500);
    id0 = res_id; c0 = res_count;
    chk("bp_id", id0, 0);
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_id != id0 || res_count != c0 || ro_en != 4'b0000) stable = 0;
    end
    chk("bp_stable", stable, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_en", ro_en, 4'b0010);
    chk("bp_valid_drop", res_valid, 0);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    res_ready = 1'b1;
    run_single('{3'd1, 16'd40, 40, 3'd1, 10, 1, 56}, "post_abort");

    // synchronous reset in SETTLE
    start_op(1'b0, 3'd3, 16'd50);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_ro_en", ro_en, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", res_valid, 0);
    chk("rstmid_id", res_id, 0);
    chk("rstmid_count", res_count, 0);
    chk("rstmid_ovf", res_ovf, 0);
    @(posedge clk); #1 rst = 1'b0;

    // out-of-range single select
    start_op(1'b0, 3'd5, 16'd100);
    @(negedge clk);
    chk("badsel_busy", busy, 0);
    chk("badsel_ro_en", ro_en, 0);
    repeat (5) @(negedge clk);
    chk("badsel_busy_later", busy, 0);

    // saturation on the 4-bit counter instance
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (res_valid2) ok = 1;
    end
    chk("sat_timeout", ok, 1);
    chk("sat_count", res_count2, 15);
    chk("sat_ovf", res_ovf2, 1);
    chk("sat_id", res_id2, 0);

    chk("ro_en_onehot0", mh, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
